if_stage_pc: RTL and testbench

- Fetch stage of the MIPS pipeline. Owns the PC register and drives the SRAM-style instruction port.
- Selects the next PC from sequential, branch, jump and exception sources. The branch target arrives from decode, built as pc_plus4_d + (sign-extended imm shifted left 2).
- Registers the IF/ID pipeline latch: instruction, PC, PC+4, valid, fetch-address-error.
- Handles stall, flush, redirects that arrive while stalled, and misaligned fetch addresses.

---
 rtl/if_stage_pc_pkg.sv | 17 +
 rtl/if_stage_pc_pc_next_sel.sv | 53 +++++
 rtl/if_stage_pc.sv | 118 +++++++++++
 tb/tb_if_stage_pc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pc_pkg.sv
// Shared CPU constants: reset vector, bubble instruction, and the exception vector
// used by the exception unit.
package cpu_defs;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_PEND = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_EXC  = 3'd4
  } pc_src_e;

endpackage

// File: rtl/if_stage_pc_pc_next_sel.sv
// Next-PC priority mux: exception > branch > jump > pending redirect > sequential,
// with the address held during a stall unless an exception forces a redirect.
module pc_next_sel
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        resetn,
  input  logic        stall_f,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        jmp_take,
  input  logic [31:0] jmp_target,
  input  logic        exc_take,
  input  logic [31:0] exc_target,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  input  logic [31:0] pc_f,
  output pc_src_e     src,
  output logic [31:0] pc_next
);

  logic [31:0] w_redirect;

  always_comb begin
    src        = SEL_SEQ;
    w_redirect = pc_f + 32'd4;
    if (exc_take) begin
      src        = SEL_EXC;
      w_redirect = exc_target;
    end else if (br_take) begin
      src        = SEL_BR;
      w_redirect = br_target;
    end else if (jmp_take) begin
      src        = SEL_JMP;
      w_redirect = jmp_target;
    end else if (pend_valid) begin
      src        = SEL_PEND;
      w_redirect = pend_target;
    end
  end

  // Holding the address keeps the synchronous SRAM output stable across a stall.
  always_comb begin
    if (!resetn)
      pc_next = RESET_PC;
    else if (stall_f && !exc_take)
      pc_next = pc_f;
    else
      pc_next = w_redirect;
  end

endmodule

// File: rtl/if_stage_pc.sv
// MIPS fetch stage: PC register, pending-redirect register, SRAM instruction port
// and the IF/ID pipeline latch.
module if_stage_pc
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        jmp_take,
  input  logic [31:0] jmp_target,
  input  logic        exc_take,
  input  logic [31:0] exc_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        adel_d
);

  logic [31:0] r_pc_f;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic [31:0] r_instr_d;
  logic        r_valid_d;
  logic        r_adel_d;

  logic [31:0] w_pc_next;
  pc_src_e     w_src;
  logic        w_misaligned;

  pc_next_sel #(
    .RESET_PC (RESET_PC)
  ) u_pc_next_sel (
    .resetn      (resetn),
    .stall_f     (stall_f),
    .br_take     (br_take),
    .br_target   (br_target),
    .jmp_take    (jmp_take),
    .jmp_target  (jmp_target),
    .exc_take    (exc_take),
    .exc_target  (exc_target),
    .pend_valid  (r_pend_valid),
    .pend_target (r_pend_target),
    .pc_f        (r_pc_f),
    .src         (w_src),
    .pc_next     (w_pc_next)
  );

  assign w_misaligned    = (r_pc_f[1:0] != 2'b00);
  assign inst_sram_addr  = w_pc_next;
  assign inst_sram_en    = resetn ? (w_pc_next[1:0] == 2'b00) : 1'b1;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  // ---- F stage: PC and pending redirect ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc_f        <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0000_0000;
    end else begin
      r_pc_f <= w_pc_next;
      if (exc_take) begin
        r_pend_valid <= 1'b0;
      end else if (stall_f && (br_take || jmp_take)) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= (w_src == SEL_BR) ? br_target : jmp_target;
      end else if (!stall_f) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // ---- IF/ID latch ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc_d       <= 32'h0000_0000;
      r_pc_plus4_d <= 32'h0000_0000;
      r_instr_d    <= NOP_INSTR;
      r_valid_d    <= 1'b0;
      r_adel_d     <= 1'b0;
    end else if (exc_take || flush_d) begin
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= r_pc_f + 32'd4;
      r_instr_d    <= NOP_INSTR;
      r_valid_d    <= 1'b0;
      r_adel_d     <= 1'b0;
    end else if (!stall_f) begin
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= r_pc_f + 32'd4;
      r_valid_d    <= 1'b1;
      r_adel_d     <= w_misaligned;
      r_instr_d    <= w_misaligned ? NOP_INSTR : inst_sram_rdata;
    end
  end

  assign pc_f       = r_pc_f;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign instr_d    = r_instr_d;
  assign valid_d    = r_valid_d;
  assign adel_d     = r_adel_d;

endmodule

// File: tb/tb_if_stage_pc.sv
// Bench for if_stage_pc: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of the fetch stage and an SRAM model.
module tb_if_stage_pc;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn, stall_f, flush_d;
  logic        br_take, jmp_take, exc_take;
  logic [31:0] br_target, jmp_target, exc_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] pc_f, pc_d, pc_plus4_d, instr_d;
  logic        valid_d, adel_d;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [31:0] m_pc, m_pt, m_pcd, m_p4d, m_ins;
  logic        m_pv, m_vld, m_adel;

  always #5 clk = ~clk;

  if_stage_pc dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall_f         (stall_f),
    .flush_d         (flush_d),
    .br_take         (br_take),
    .br_target       (br_target),
    .jmp_take        (jmp_take),
    .jmp_target      (jmp_target),
    .exc_take        (exc_take),
    .exc_target      (exc_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .pc_f            (pc_f),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .instr_d         (instr_d),
    .valid_d         (valid_d),
    .adel_d          (adel_d)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous 1-cycle SRAM
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= memf(inst_sram_addr);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic cyc(input bit rn, input bit st, input bit fl,
                     input bit bt, input logic [31:0] btg,
                     input bit jt, input logic [31:0] jtg,
                     input bit et, input logic [31:0] etg);
    logic [31:0] sel, nxt;
    logic        mis;
    resetn = rn; stall_f = st; flush_d = fl;
    br_take = bt; br_target = btg;
    jmp_take = jt; jmp_target = jtg;
    exc_take = et; exc_target = etg;
    #1;
    if (et)        sel = etg;
    else if (bt)   sel = btg;
    else if (jt)   sel = jtg;
    else if (m_pv) sel = m_pt;
    else           sel = m_pc + 32'd4;
    if (!rn)             nxt = RST_PC;
    else if (st && !et)  nxt = m_pc;
    else                 nxt = sel;
    check("sram_addr", inst_sram_addr, nxt);
    check("sram_en", {31'd0, inst_sram_en}, {31'd0, (!rn) || (nxt[1:0] == 2'b00)});
    check("sram_wen_wdata", {28'd0, inst_sram_wen} | inst_sram_wdata, 32'd0);
    if (!rn) begin
      m_pc = RST_PC; m_pv = 1'b0; m_pt = 32'd0;
      m_pcd = 32'd0; m_p4d = 32'd0; m_ins = 32'd0; m_vld = 1'b0; m_adel = 1'b0;
    end else begin
      mis = (m_pc[1:0] != 2'b00);
      if (et || fl) begin
        m_pcd = m_pc; m_p4d = m_pc + 32'd4; m_ins = 32'd0; m_vld = 1'b0; m_adel = 1'b0;
      end else if (!st) begin
        m_pcd = m_pc; m_p4d = m_pc + 32'd4; m_vld = 1'b1; m_adel = mis;
        m_ins = mis ? 32'd0 : memf(m_pc);
      end
      if (et) m_pv = 1'b0;
      else if (st && (bt || jt)) begin m_pv = 1'b1; m_pt = bt ? btg : jtg; end
      else if (!st) m_pv = 1'b0;
      m_pc = nxt;
    end
    @(posedge clk); #1;
    check("pc_f", pc_f, m_pc);
    check("pc_d", pc_d, m_pcd);
    check("pc_plus4_d", pc_plus4_d, m_p4d);
    check("instr_d", instr_d, m_ins);
    check("valid_d", {31'd0, valid_d}, {31'd0, m_vld});
    check("adel_d", {31'd0, adel_d}, {31'd0, m_adel});
  endtask

  task automatic run(input bit st);
    cyc(1, st, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
  endtask

  initial begin
    logic [31:0] t;
    m_pc = 32'd0; m_pt = 32'd0; m_pv = 1'b0;
    m_pcd = 32'd0; m_p4d = 32'd0; m_ins = 32'd0; m_vld = 1'b0; m_adel = 1'b0;
    @(posedge clk); #1;

    // Reset and sequential fetch
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc_f", pc_f, 32'hBFC0_0000);
    check("rst_valid", {31'd0, valid_d}, 32'd0);
    check("rst_instr", instr_d, 32'd0);
    run(0);
    check("seq_pc1", pc_f, 32'hBFC0_0004);
    check("seq_valid", {31'd0, valid_d}, 32'd1);
    run(0);
    check("seq_pc2", pc_f, 32'hBFC0_0008);

    // Branch with delay slot BFC00008
    cyc(1, 0, 0, 1, 32'hBFC0_0100, 0, 0, 0, 0);
    check("br_pc", pc_f, 32'hBFC0_0100);
    check("br_slot_pc_d", pc_d, 32'hBFC0_0008);
    run(0);

    // Stall 3 cycles with jump pulse in the first
    cyc(1, 1, 0, 0, 0, 1, 32'hBFC0_0200, 0, 0);
    check("stall_hold", pc_f, 32'hBFC0_0104);
    run(1);
    run(1);
    run(0);
    check("pend_consumed", pc_f, 32'hBFC0_0200);
    run(0);
    check("pend_cleared", pc_f, 32'hBFC0_0204);

    // Exception during stall clears a pending redirect
    cyc(1, 1, 0, 0, 0, 1, 32'hBFC0_0500, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
    check("exc_pc", pc_f, 32'hBFC0_0380);
    check("exc_bubble", {31'd0, valid_d}, 32'd0);
    run(0);
    check("exc_no_pend", pc_f, 32'hBFC0_0384);

    // Misaligned jump target
    cyc(1, 0, 0, 0, 0, 1, 32'hBFC0_0102, 0, 0);
    run(0);
    check("adel_flag", {31'd0, adel_d}, 32'd1);
    check("adel_pc_d", pc_d, 32'hBFC0_0102);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380);

    // Flush and reset during a stall with pending redirect
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'hBFC0_0600, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_pc", pc_f, 32'hBFC0_0000);
    check("rst_mid_valid", {31'd0, valid_d}, 32'd0);
    run(0);
    check("rst_mid_resume", pc_f, 32'hBFC0_0004);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      t = 32'hBFC0_0000 | ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom_range(1, 3));
      cyc($urandom_range(0, 63) != 0,
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 9) == 0, t,
          $urandom_range(0, 9) == 0, t ^ 32'h0000_0ff0,
          $urandom_range(0, 19) == 0, 32'hBFC0_0380 + (32'($urandom_range(0, 3)) << 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
